// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Drains a byte FIFO and serialises each byte as 8N1 (8E1 when
//            UART_TX_PARITY_EN is defined), LSB first, registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
    parameter int CLKDIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       oready,
    output logic       rden,
    input  logic [7:0] odata,
    input  logic       err,
    output logic       txd,
    output logic       busy,
    output logic       txerr
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_load   = 3'd2;
    localparam logic [2:0] c_st_start  = 3'd3;
    localparam logic [2:0] c_st_data   = 3'd4;
    localparam logic [2:0] c_st_stop   = 3'd5;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd6;
`endif
    localparam logic [15:0] c_last = 16'(CLKDIV - 1);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_empty_pop;
    logic        r_txd;
    logic        r_rden;
    logic        r_busy;
    logic        r_txerr;
`ifdef UART_TX_PARITY_EN
    logic        r_par;
`endif

    logic [2:0]  w_state_next;
    logic [15:0] w_cnt_next;
    logic [2:0]  w_bit_next;
    logic [7:0]  w_shift_next;
    logic        w_bit_end;
    logic        w_txd_next;
    logic        w_rden_next;
    logic        w_busy_next;
    logic        w_txerr_next;

    assign w_bit_end = (r_cnt == c_last);

    // State, datapath and output registers; outputs are registered copies
    // of values derived from the next state so they line up with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_empty_pop <= 1'b0;
            r_txd       <= 1'b1;
            r_rden      <= 1'b0;
            r_busy      <= 1'b0;
            r_txerr     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_txd   <= w_txd_next;
            r_rden  <= w_rden_next;
            r_busy  <= w_busy_next;
            r_txerr <= w_txerr_next;
            if (r_state == c_st_fetch) begin
                r_empty_pop <= ~oready;
            end
`ifdef UART_TX_PARITY_EN
            if (r_state == c_st_load) begin
                r_par <= ^odata;
            end
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        case (r_state)
            c_st_idle: begin
                w_cnt_next = '0;
                w_bit_next = '0;
                if (en && oready) begin
                    w_state_next = c_st_fetch;
                end
            end
            c_st_fetch: begin
                w_state_next = c_st_load;
            end
            c_st_load: begin
                w_cnt_next = '0;
                // A pop of an empty FIFO returns garbage: drop it.
                if (r_empty_pop) begin
                    w_state_next = c_st_idle;
                end else begin
                    w_shift_next = odata;
                    w_state_next = c_st_start;
                end
            end
            c_st_start: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = c_st_data;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            c_st_data: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next = c_st_parity;
`else
                        w_state_next = c_st_stop;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            c_st_parity: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_state_next = c_st_stop;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
`endif
            c_st_stop: begin
                if (w_bit_end) begin
                    w_cnt_next   = '0;
                    w_state_next = c_st_idle;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_bit_next   = '0;
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_comb begin
        w_txd_next   = 1'b1;
        w_rden_next  = (w_state_next == c_st_fetch);
        w_busy_next  = (w_state_next != c_st_idle);
        w_txerr_next = r_txerr | err | ((r_state == c_st_load) && r_empty_pop);
        case (w_state_next)
            c_st_start:  w_txd_next = 1'b0;
            c_st_data:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            c_st_parity: w_txd_next = r_par;
`endif
            default:     w_txd_next = 1'b1;
        endcase
    end

    assign txd   = r_txd;
    assign rden  = r_rden;
    assign busy  = r_busy;
    assign txerr = r_txerr;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Directed bench for fifo_uart_tx with a byte FIFO model and an
//            expected-byte queue checked cycle by cycle against the serial line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int P = NB * D + 3;

    logic       clk;
    logic       reset;
    logic       en;
    logic       err;
    logic       force_ready;
    logic       rden;
    logic       txd;
    logic       busy;
    logic       txerr;
    logic       oready;
    logic [7:0] odata;

    logic [7:0] mem [0:63];
    int         wr_ptr;
    int         rd_ptr;
    logic [7:0] exp_q [$];
    logic       txerr_exp;
    int         n_chk;
    int         n_fail;

    fifo_uart_tx #(.CLKDIV(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .oready (oready),
        .rden   (rden),
        .odata  (odata),
        .err    (err),
        .txd    (txd),
        .busy   (busy),
        .txerr  (txerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte FIFO model: data appears on the cycle after the pop strobe.
    assign oready = (wr_ptr != rd_ptr) || force_ready;
    initial begin
        rd_ptr = 0;
        odata  = 8'h00;
    end
    always @(posedge clk) begin
        if (rden && (wr_ptr != rd_ptr)) begin
            odata  <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    function automatic logic exp_txd(input int j, input logic [7:0] b);
        int s;
        if (j < 3) return 1'b1;
        s = (j - 3) / D;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        if (s == 9 && NB == 11) return ^b;
        return 1'b1;
    endfunction

    task automatic idle_check(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk({tag, "_rden"}, rden, 0);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_txd"}, txd, 1);
            chk({tag, "_txerr"}, txerr, txerr_exp);
        end
    endtask

    // Checks n back-to-back frames, one cycle at a time, from the cycle after
    // the FIFO becomes non-empty; j == P is the IDLE decision cycle.
    task automatic run_frames(input int n, input int en_off_at, input int err_at);
        logic [7:0] b;
        int         j;
        b = 8'h00;
        for (int i = 1; i <= n * P; i++) begin
            j = (i - 1) % P + 1;
            @(negedge clk);
            if (j == 1) begin
                chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) b = exp_q.pop_front();
            end
            chk("rden", rden, 32'(j == 1));
            chk("txd", txd, exp_txd(j, b));
            chk("busy", busy, 32'(j < P));
            chk("txerr", txerr, txerr_exp);
            if (i == en_off_at) en = 1'b0;
            if (i == err_at) begin
                err       = 1'b1;
                txerr_exp = 1'b1;
            end else begin
                err = 1'b0;
            end
        end
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        wr_ptr      = 0;
        en          = 1'b0;
        err         = 1'b0;
        force_ready = 1'b0;
        reset       = 1'b0;
        txerr_exp   = 1'b0;

        // Reset and idle
        repeat (5) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_rden", rden, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txerr", txerr, 0);
        reset = 1'b1;
        en    = 1'b1;
        idle_check(50, "idle");

        // Single frame 0xA5
        push_byte(8'hA5);
        run_frames(1, -1, -1);

        // Back-to-back 0x00 then 0xFF
        push_byte(8'h00);
        push_byte(8'hFF);
        run_frames(2, -1, -1);

        // en dropped during data bit 3: frame completes, no further fetch
        push_byte(8'h3C);
        push_byte(8'h5A);
        run_frames(1, 3 + 4 * D, -1);
        idle_check(3 * P, "en_off");
        en = 1'b1;
        run_frames(1, -1, -1);

        // Reset in the middle of DATA
        push_byte(8'h96);
        repeat (15) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rden", rden, 0);
        void'(exp_q.pop_front());
        @(negedge clk);
        reset = 1'b1;
        idle_check(10, "post_rst");

        // Error pulse mid-frame, sticky until reset
        push_byte(8'hC3);
        run_frames(1, -1, 10);
        idle_check(5, "sticky");
        reset = 1'b0;
        txerr_exp = 1'b0;
        #1;
        chk("err_clear", txerr, 0);
        @(negedge clk);
        reset = 1'b1;

        // Pop of an empty FIFO
        force_ready = 1'b1;
        @(negedge clk);
        chk("empty_rden", rden, 1);
        force_ready = 1'b0;
        @(negedge clk);
        chk("empty_load_busy", busy, 1);
        chk("empty_load_txerr", txerr, 0);
        @(negedge clk);
        chk("empty_txerr", txerr, 1);
        chk("empty_busy", busy, 0);
        chk("empty_txd", txd, 1);
        txerr_exp = 1'b1;
        idle_check(5, "empty_idle");

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07);
        push_byte(8'hA5);
        run_frames(2, -1, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the byte FIFO buffer; drains it one byte at a time and serialises each byte onto an asynchronous serial line.
- Frame format: 8N1, LSB first, or 8E1 with the optional feature.
- Talks to the FIFO read side: oready (FIFO non-empty), rden (pop strobe), odata (byte), err (FIFO error).
- Sits between the FIFO buffer and the board TX pin.

Parameters:
CLKDIV, 16, clk cycles per serial bit; legal range 2..65535; bit counter is 16 bits wide.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
en  in  1  transmit enable; sampled only in IDLE.
oready  in  1  FIFO has data (non-empty).
rden  out  1  FIFO pop strobe; one-cycle pulse.
odata  in  8  FIFO read data; valid on the cycle after rden=1.
err  in  1  FIFO error flag.
txd  out  1  serial output; idles high.
busy  out  1  high in every state except IDLE.
txerr  out  1  sticky error.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - txd=1, rden=0, busy=0, txerr=0.
  - Shift register and bit/cycle counters are cleared.
  - Reset mid-frame aborts the frame immediately; txd returns high with no glitch low.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY (feature only), STOP.
- IDLE: if en=1 and oready=1, go to FETCH; otherwise stay; txd=1.
- FETCH: rden=1 for this single cycle only; next state is LOAD.
- LOAD:
  - Capture odata into the 8-bit shift register.
  - Clear the cycle counter; go to START.
  - If oready was 0 while in FETCH (pop of an empty FIFO), set txerr, discard the byte and go to IDLE.
- START: txd=0 for exactly CLKDIV cycles; then go to DATA with bit index 0.
- DATA:
  - txd=shift[0] for CLKDIV cycles, then shift right and increment the bit index.
  - After bit 7, go to PARITY (feature) or STOP.
- STOP: txd=1 for CLKDIV cycles; then go to IDLE.
- Timing (8N1):
  - First txd low edge is 3 cycles after the IDLE cycle that saw en&oready.
  - Frame is 10*CLKDIV cycles.
  - Back-to-back byte period is 10*CLKDIV+3 cycles; minimum inter-frame high gap is 3 cycles (IDLE, FETCH, LOAD) beyond the stop bit.
- en deasserted mid-frame: the current frame completes; no further fetch.
- oready drops after FETCH: no effect; the byte was already popped.
- err=1 on any cycle sets txerr. txerr clears only on reset; the frame in progress continues.
- Cycle counter runs 0..CLKDIV-1 and wraps at each bit boundary; no drift across the frame.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA bit 7.
  - txd = XOR of the 8 data bits (even parity) for CLKDIV cycles.
  - Frame is 11*CLKDIV cycles; byte period is 11*CLKDIV+3 cycles.
- Undefined: PARITY state and parity logic are absent; the frame is 10*CLKDIV cycles.

Test Plan:
1. Reset and idle: reset low for 5 cycles, then high; oready=0 -> txd=1, rden=0, busy=0, txerr=0 for 50 cycles.
2. Single frame, CLKDIV=4, en=1, FIFO holds 0xA5:
   - rden high exactly 1 cycle, 1 cycle after oready is seen.
   - txd low starts 3 cycles after oready is seen.
   - txd = 0, then 1,0,1,0,0,1,0,1, then 1, each bit for 4 cycles.
   - busy high for 42 cycles.
3. Back-to-back, CLKDIV=4, FIFO holds 0x00 then 0xFF:
   - Two rden pulses 43 cycles apart.
   - Second start bit begins 3 cycles after the first stop bit ends.
   - Every data bit of frame 2 is 1.
4. Enable and reset mid-frame:
   - en=0 during bit 3 of a frame: the frame completes; no further rden while oready=1.
   - reset low during DATA: txd=1 on the same cycle; busy=0; no rden until the next IDLE decision.
5. Error: pulse err=1 for 1 cycle mid-frame -> txerr=1 from the next cycle; the frame finishes unchanged; txerr persists until reset.
6. Parity (UART_TX_PARITY_EN), CLKDIV=4, byte 0x07:
   - Data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop bit 1.
   - Byte 0xA5 gives parity bit 0.
   - Frame is 44 cycles.
